// File: rtl/maze_pkg.sv
// maze_pkg: shared maze grid geometry, direction codes, FSM states and wall-bit index helpers.
// Used by maze_generator, maze_lfsr users, scene_exhibitor and the collision logic.
package maze_pkg;
    localparam int MAZE_W      = 10;
    localparam int MAZE_H      = 15;
    localparam int MAZE_CELLS  = 150;
    localparam int H_WALL_BITS = 160;
    localparam int V_WALL_BITS = 165;

    typedef enum logic [1:0] {DIR_RIGHT, DIR_DOWN, DIR_LEFT, DIR_UP} dir_e;
    typedef enum logic [1:0] {S_IDLE, S_INIT, S_WALK, S_DONE} gen_state_e;

    // Horizontal line 0 is the top border, MSB-first packing.
    function automatic int h_bit(input int line, input int col);
        return H_WALL_BITS - 1 - (MAZE_W * line + col);
    endfunction

    // Vertical line 0 is the left border, MSB-first packing.
    function automatic int v_bit(input int row, input int line);
        return V_WALL_BITS - 1 - ((MAZE_W + 1) * row + line);
    endfunction
endpackage

// File: rtl/maze_lfsr.sv
// maze_lfsr: 32-bit right-shifting Galois LFSR (taps 0x80200003).
// Ports: clk, rst (sync, active-high), load (take seed; 0 becomes 1), seed[31:0],
//        step (advance once), value[31:0] (current state).
module maze_lfsr (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] value
);
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic [31:0] value_q, value_d;

    always_comb begin
        value_d = load ? ((seed == 32'd0) ? 32'd1 : seed)
                : step ? ({1'b0, value_q[31:1]} ^ (value_q[0] ? TAPS : 32'd0))
                : value_q;
    end

    always_ff @(posedge clk) begin
        if (rst) value_q <= 32'd1;
        else     value_q <= value_d;
    end

    assign value = value_q;
endmodule

// File: rtl/maze_generator.sv
// maze_generator: random perfect maze (10x15 cells) by stack-based depth-first search.
// Ports: clk, rst (sync, active-high), enable (start, held until busy falls),
//        seed[31:0] (LFSR seed, sampled in INIT), busy (low only when the maze is finished),
//        h_walls[159:0], v_walls[164:0] (wall lines, MSB-first).
// Optional: define MAZE_GEN_EXITS_EN to open the top of cell (0,0) and the bottom of cell (9,14).
module maze_generator
    import maze_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [31:0]            seed,
    output logic                   busy,
    output logic [H_WALL_BITS-1:0] h_walls,
    output logic [V_WALL_BITS-1:0] v_walls
);
    gen_state_e             state_q, state_d;
    logic [H_WALL_BITS-1:0] h_walls_q, h_walls_d;
    logic [V_WALL_BITS-1:0] v_walls_q, v_walls_d;
    logic [MAZE_CELLS-1:0]  visited_q, visited_d;
    logic [7:0]             stack_q [MAZE_CELLS];
    logic [7:0]             stack_d [MAZE_CELLS];
    logic [7:0]             sp_q, sp_d;

    logic        lfsr_load, lfsr_step;
    logic [1:0]  rot;
    logic [29:0] lfsr_hi_unused;

    logic [7:0] cur;
    logic [3:0] avail;
    logic [1:0] cand;
    dir_e       dir;
    int         ci, cx, cy, nb;

    maze_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .value ({lfsr_hi_unused, rot})
    );

    always_comb begin
        state_d   = state_q;
        h_walls_d = h_walls_q;
        v_walls_d = v_walls_q;
        visited_d = visited_q;
        sp_d      = sp_q;
        stack_d   = stack_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        cur = stack_q[sp_q - 8'd1];
        ci  = int'(cur);
        cx  = ci % MAZE_W;
        cy  = ci / MAZE_W;
        avail[DIR_RIGHT] = (cx < MAZE_W - 1) ? !visited_q[ci + 1] : 1'b0;
        avail[DIR_DOWN]  = (cy < MAZE_H - 1) ? !visited_q[ci + MAZE_W] : 1'b0;
        avail[DIR_LEFT]  = (cx > 0) ? !visited_q[ci - 1] : 1'b0;
        avail[DIR_UP]    = (cy > 0) ? !visited_q[ci - MAZE_W] : 1'b0;
        // Scan downwards so the first available direction after rot wins.
        dir  = dir_e'(rot);
        cand = rot;
        for (int k = 3; k >= 0; k--) begin
            cand = rot + 2'(k);
            if (avail[cand]) dir = dir_e'(cand);
        end
        nb = (dir == DIR_RIGHT) ? ci + 1
           : (dir == DIR_DOWN)  ? ci + MAZE_W
           : (dir == DIR_LEFT)  ? ci - 1
           : ci - MAZE_W;
        unique case (state_q)
            S_IDLE: if (enable) state_d = S_INIT;
            S_INIT: begin
                h_walls_d    = '1;
                v_walls_d    = '1;
`ifdef MAZE_GEN_EXITS_EN
                h_walls_d[h_bit(0, 0)]                = 1'b0;
                h_walls_d[h_bit(MAZE_H, MAZE_W - 1)]  = 1'b0;
`endif
                visited_d    = '0;
                visited_d[0] = 1'b1;
                stack_d[0]   = 8'd0;
                sp_d         = 8'd1;
                lfsr_load    = 1'b1;
                state_d      = S_WALK;
            end
            S_WALK: begin
                if (|avail) begin
                    if (dir[0]) h_walls_d[h_bit((dir == DIR_DOWN) ? cy + 1 : cy, cx)] = 1'b0;
                    else        v_walls_d[v_bit(cy, (dir == DIR_RIGHT) ? cx + 1 : cx)] = 1'b0;
                    visited_d[nb] = 1'b1;
                    stack_d[sp_q] = 8'(nb);
                    sp_d          = sp_q + 8'd1;
                    lfsr_step     = 1'b1;
                end else begin
                    sp_d = sp_q - 8'd1;
                    if (sp_q == 8'd1) state_d = S_DONE;
                end
            end
            S_DONE: if (!enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            h_walls_q <= '1;
            v_walls_q <= '1;
            visited_q <= '0;
            sp_q      <= 8'd0;
        end else begin
            state_q   <= state_d;
            h_walls_q <= h_walls_d;
            v_walls_q <= v_walls_d;
            visited_q <= visited_d;
            sp_q      <= sp_d;
        end
    end

    always_ff @(posedge clk) stack_q <= stack_d;

    assign busy    = (state_q != S_DONE);
    assign h_walls = h_walls_q;
    assign v_walls = v_walls_q;
endmodule
